// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// presents the latched instruction to the decoder and halts on a dead memory.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Br,
  input  logic        J,
  input  logic        PCWr,
  input  logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_off;
  logic [31:0]      w_next_pc;
  logic             w_timeout;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Next-PC select: jump outranks branch, both outrank sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (J) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (Br) begin
      w_next_pc = w_pc_plus4 + w_br_off;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            r_state <= S_FETCH;
            // Without PCWr the same address is simply refetched.
            if (PCWr) begin
              r_pc <= w_next_pc;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_EXEC);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign fetch_err   = r_err;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder/control unit.
- Owns the PC register and issues requests to instruction memory using a req/ack handshake.
- Presents a latched instruction to the decoder with a valid flag.
- Computes the next PC from the decoder's Br/J/PCWr outputs and supplies pc_plus4 for the jal link write.
- Includes a watchdog that halts the stage on a memory that never acknowledges.

Parameters:
- RESET_PC, 32'h0000_3000: PC value loaded on reset.
- TIMEOUT, 255: maximum FETCH cycles without ack before halting; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; TIMEOUT must fit in CNT_W bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  latched instruction presented to the decoder.
- instr_valid  out  1  instr is valid and being executed this cycle.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, used as the jal link value.
- Br  in  1  branch taken, from the decoder.
- J  in  1  jump (jal), from the decoder.
- PCWr  in  1  PC write enable, from the decoder.
- stall  in  1  hold the current instruction in EXEC.
- fetch_err  out  1  sticky watchdog error.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, any state, including mid-FETCH or mid-EXEC):
  - state=IDLE, pc=RESET_PC, instr=0, counter=0, fetch_err=0.
  - Outputs during and immediately after reset: imem_req=0, instr_valid=0.
- IDLE: unconditionally goes to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - If imem_ack: instr<=imem_rdata, counter<=0, go to EXEC.
  - Otherwise counter increments.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: go to HALT and set fetch_err<=1.
- EXEC:
  - instr_valid=1, imem_req=0.
  - If stall: hold state; pc and instr are unchanged.
  - Otherwise go to FETCH. If PCWr, pc<=next_pc; if !PCWr, pc holds and the same address is refetched.
- next_pc priority is J > Br > sequential:
  - J: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Br: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - Otherwise: pc_plus4.
- HALT:
  - imem_req=0, instr_valid=0, pc frozen.
  - fetch_err stays 1 until reset.
- Arithmetic:
  - All additions are 32-bit modulo 2^32; pc 32'hFFFF_FFFC advances to 32'h0000_0000.
  - pc_plus4 is combinational from pc.
- Input qualification:
  - imem_ack is ignored outside FETCH.
  - Br, J, PCWr and stall are sampled only in EXEC.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with ack in the same cycle, then EXEC).
  - First imem_req is asserted 1 cycle after reset deasserts.
- instr_valid, imem_req and imem_addr are decoded from state and registers only, with no combinational path from inputs.
- pc never holds a misaligned value; bits [1:0] are always 0.

Test Plan:
- Reset then zero-wait ack memory returning addu words, PCWr=1, Br=J=0 -> imem_addr sequence 3000, 3004, 3008; instr_valid every second cycle.
- At pc=3010 with instr=beq imm16=16'hFFFC, Br=1 -> next imem_addr=3004. Repeat with imm16=0003 -> 3020.
- At pc=3010 with instr=jal target 26'h0000C10, J=1 and Br=1 together -> next imem_addr=00003040 (J wins); pc_plus4=3014 during EXEC.
- ack delayed 5 cycles -> imem_req stays high for 6 cycles, instr latches the word, no fetch_err. With TIMEOUT=4 and no ack -> HALT after 4 FETCH cycles, fetch_err=1, imem_req=0 thereafter.
- stall=1 for 3 cycles in EXEC -> instr_valid held high 4 cycles, pc unchanged. PCWr=0 -> same address refetched.
- rst asserted mid-FETCH with imem_ack pulsing -> outputs go to reset values immediately (asynchronously, before the next clock edge), pc=3000, first request is 1 cycle after release. Spurious ack in EXEC or IDLE -> ignored.
